pulse_spacer: RTL and testbench
===============================

Name: pulse_spacer

Overview:
- Upstream conditioning stage for pulse_sync, in the source (fast) clock domain.
- Accepts bursty single-cycle event strobes, counts the ones still pending, and re-emits them as single-cycle pulses with a guaranteed minimum low gap between them.
- The gap keeps every pulse slow enough for pulse_sync to carry it into the slower destination domain without loss.
- Lost events (counter saturation) are flagged to software/debug logic.

Parameters:
- CNT_WIDTH, 8, width of the pending-event counter; max pending = 2^CNT_WIDTH-1.
- MIN_GAP, 7, number of low cycles forced after every output pulse. Must be ≥1. Default sized for 10 ns source / 24 ns destination: period 8 source cycles = 80 ns > 3 destination cycles.

Ports:
- clk  input  1  source-domain clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- event_in  input  1  event strobe; every cycle sampled high counts as one event, so consecutive high cycles are distinct events.
- overflow_clr  input  1  clears the overflow flag.
- pulse_out  output  1  registered single-cycle active-high pulse; connects to pulse_sync.pulse_in.
- pending  output  CNT_WIDTH  registered count of events accepted but not yet emitted.
- overflow  output  1  sticky flag; at least one event was dropped.
- busy  output  1  high while state != IDLE or pending != 0 (combinational from registers).

Behaviour:
- Reset (async, rst=1): state=IDLE, pulse_out=0, pending=0, overflow=0, gap counter=0, so busy=0. Outputs drop immediately, not at the next edge. Mid-operation reset discards all pending events; no pulse is emitted after release unless new events arrive.
- FSM states: IDLE, PULSE, GAP. pulse_out=1 exactly while in PULSE (registered state decode).
- IDLE: at an edge where pending!=0 → PULSE; pending decrements at that same edge. Otherwise stay in IDLE.
- PULSE: lasts exactly one cycle → GAP at the next edge; gap counter loaded with MIN_GAP-1.
- GAP: gap counter decrements each edge while nonzero. At the edge where it is 0:
  - pending!=0 → PULSE, with pending decrementing at that edge.
  - else → IDLE.
  - GAP therefore lasts exactly MIN_GAP cycles, and the back-to-back pulse period is MIN_GAP+1 cycles.
- Latency: event_in sampled at edge N with pending=0 and state IDLE → pending=1 after N → pulse_out high from edge N+1 to edge N+2.
- Pending arithmetic, per edge:
  - inc = event_in.
  - dec = entering PULSE.
  - inc & dec → unchanged.
  - inc only → +1, saturating at 2^CNT_WIDTH-1.
  - dec only → −1 (never below 0; dec requires pending!=0).
- Overflow: set when inc & !dec & pending==max; the event is dropped.
  - inc while pending==max but dec in the same cycle is not a loss.
  - overflow_clr clears it; if set and clear coincide, set wins.
  - overflow is unaffected by anything except rst and overflow_clr.
- event_in arriving during PULSE/GAP is only counted; it never shortens the gap.
- Gap counter width: $clog2(MIN_GAP+1); no wrap, because it is loaded only on PULSE→GAP.
- Invariant: pulse_out is never high in two consecutive cycles, and any two rising edges are ≥MIN_GAP+1 cycles apart.

Test Plan:
1. Single event: event_in high for 1 cycle at edge 5 → pending=1 after edge 5; pulse_out high for exactly cycle 6→7; pending=0 after edge 6; busy low after edge 14 (MIN_GAP=7).
2. Burst: event_in high at edges 0,1,2 → pending sequence 1,1,2,…; 3 pulses with rising edges at edges 1, 9, 17; pending=0 and busy=0 after the final gap.
3. Saturation (CNT_WIDTH=2): event_in high at edges 0–5 → pending reaches 3 at edge 3, overflow=1 from edge 4; exactly 4 pulses emitted; 2 events lost.
4. Overflow clear: overflow_clr alone → overflow=0 next edge. overflow_clr coincident with a new saturation loss → overflow stays 1.
5. Reset mid-GAP with pending=2 → pulse_out, pending, overflow, busy all 0 before the next edge; after release with event_in=0 for 30 cycles, no pulse.
6. Integration with pulse_sync (clk 10 ns, clk_out 24 ns): 5-cycle event_in burst → 5 pulse_out_src pulses and exactly 5 destination pulses counted; none merged.

Source files
------------

// File: rtl/pulse_spacer.sv
// -----------------------------------------------------------------------------
// pulse_spacer
//   Source-domain conditioning stage ahead of pulse_sync. Bursty single-cycle
//   event strobes are counted into a pending counter and re-emitted as
//   single-cycle pulses. Every output pulse is followed by at least MIN_GAP low
//   cycles, so pulse_sync can carry each pulse into the slower domain without
//   merging or losing it. Events arriving while the counter is full are dropped
//   and reported through a sticky overflow flag.
//
// Parameters
//   CNT_WIDTH : width of the pending-event counter (max 2^CNT_WIDTH-1 pending)
//   MIN_GAP   : low cycles forced after every output pulse (must be >= 1)
//
// Ports
//   clk          in   source-domain clock, posedge
//   rst          in   asynchronous active-high reset
//   event_in     in   event strobe, each high cycle is one event
//   overflow_clr in   clears the sticky overflow flag (a new loss wins)
//   pulse_out    out  registered single-cycle pulse towards pulse_sync
//   pending      out  registered count of accepted, not yet emitted events
//   overflow     out  sticky flag, at least one event was dropped
//   busy         out  high while not IDLE or events are still pending
// -----------------------------------------------------------------------------
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | nothing in flight; leaves as soon as pending is nonzero
//   PULSE | pulse_out high for exactly one cycle
//   GAP   | forced low time, MIN_GAP cycles, counted down by gap_q
// -----------------------------------------------------------------------------
module pulse_spacer #(
  parameter int CNT_WIDTH = 8,
  parameter int MIN_GAP   = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 event_in,
  input  logic                 overflow_clr,
  output logic                 pulse_out,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 overflow,
  output logic                 busy
);

  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] PEND_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [CNT_WIDTH-1:0] pend_q, pend_d;
  logic                 ovf_q, ovf_d;
  logic                 pulse_q, pulse_d;

  logic                 dec;
  logic                 drop;

  // Next-state logic. dec marks the edge that enters PULSE; that edge consumes
  // one pending event.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) begin
          state_d = PULSE;
          dec     = 1'b1;
        end
      end
      PULSE: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        // Loaded with MIN_GAP-1 and exiting at zero gives exactly MIN_GAP
        // cycles in GAP, i.e. a back-to-back period of MIN_GAP+1.
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (pend_q != '0) begin
          state_d = PULSE;
          dec     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Pending counter and loss detection. A simultaneous accept and emit leaves
  // the count unchanged, so an event arriving at full count is not lost then.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    case ({event_in, dec})
      2'b10: begin
        if (pend_q == PEND_MAX) begin
          drop = 1'b1;
        end else begin
          pend_d = pend_q + CNT_WIDTH'(1);
        end
      end
      2'b01:   pend_d = pend_q - CNT_WIDTH'(1);
      default: pend_d = pend_q;
    endcase
  end

  // Sticky flag: a loss in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (overflow_clr) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  always_comb begin
    pulse_d = (state_d == PULSE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_out = pulse_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign busy      = (state_q != IDLE) || (pend_q != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
module tb_pulse_spacer;

  localparam int GAP = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic event_in = 1'b0;
  logic overflow_clr = 1'b0;

  logic       pulse_a, ovf_a, busy_a;
  logic [7:0] pend_a;
  logic       pulse_b, ovf_b, busy_b;
  logic [1:0] pend_b;

  always #5 clk = ~clk;

  // Default-sized instance and a narrow-counter instance for saturation.
  pulse_spacer #(.CNT_WIDTH(8), .MIN_GAP(GAP)) u_a (
    .clk(clk), .rst(rst), .event_in(event_in), .overflow_clr(overflow_clr),
    .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a), .busy(busy_a)
  );

  pulse_spacer #(.CNT_WIDTH(2), .MIN_GAP(GAP)) u_b (
    .clk(clk), .rst(rst), .event_in(event_in), .overflow_clr(overflow_clr),
    .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int k = 0;             // index of the most recent clock edge
  int pc_a = 0;
  int pc_b = 0;

  // Reference model: a pulse may start at edge k when events are waiting and
  // at least GAP+1 edges have passed since the previous pulse started.
  int m_pend [2];
  int m_ovf  [2];
  int m_last [2];
  int m_max  [2] = '{255, 3};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0;
      m_ovf[i]  = 0;
      m_last[i] = -1000;
    end
  endtask

  task automatic model_edge(input logic ev, input logic clr);
    for (int i = 0; i < 2; i++) begin
      bit fire;
      bit lost;
      fire = (m_pend[i] > 0) && (k - m_last[i] >= GAP + 1);
      lost = 1'b0;
      if (fire) m_last[i] = k;
      if (ev && !fire) begin
        if (m_pend[i] == m_max[i]) lost = 1'b1;
        else m_pend[i] = m_pend[i] + 1;
      end else if (!ev && fire) begin
        m_pend[i] = m_pend[i] - 1;
      end
      if (clr)  m_ovf[i] = 0;
      if (lost) m_ovf[i] = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_busy(input int i);
    return ((m_pend[i] != 0) || (k - m_last[i] <= GAP)) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_all();
    chk("a_pulse",   {31'd0, pulse_a}, (m_last[0] == k) ? 32'd1 : 32'd0);
    chk("a_pending", {24'd0, pend_a},  m_pend[0]);
    chk("a_overflow",{31'd0, ovf_a},   m_ovf[0]);
    chk("a_busy",    {31'd0, busy_a},  m_busy(0));
    chk("b_pulse",   {31'd0, pulse_b}, (m_last[1] == k) ? 32'd1 : 32'd0);
    chk("b_pending", {30'd0, pend_b},  m_pend[1]);
    chk("b_overflow",{31'd0, ovf_b},   m_ovf[1]);
    chk("b_busy",    {31'd0, busy_b},  m_busy(1));
  endtask

  // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next.
  task automatic step(input logic ev, input logic clr);
    event_in     = ev;
    overflow_clr = clr;
    @(posedge clk);
    k++;
    model_edge(ev, clr);
    #1;
    check_all();
    pc_a += int'(pulse_a);
    pc_b += int'(pulse_b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // Reset applied mid-cycle: outputs must drop before any clock edge.
  task automatic do_reset();
    event_in     = 1'b0;
    overflow_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    chk("rst_pulse",   {31'd0, pulse_a | pulse_b}, 32'd0);
    chk("rst_pending", {22'd0, pend_a, pend_b},    32'd0);
    chk("rst_overflow",{31'd0, ovf_a | ovf_b},     32'd0);
    chk("rst_busy",    {31'd0, busy_a | busy_b},   32'd0);
    repeat (2) begin
      @(posedge clk);
      k++;
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    do_reset();

    // Single event: pulse one edge after acceptance, busy clears after gap.
    idle(3);
    step(1'b1, 1'b0);
    chk("t1_pend_after_event", {24'd0, pend_a}, 32'd1);
    step(1'b0, 1'b0);
    chk("t1_pulse_next_edge", {31'd0, pulse_a}, 32'd1);
    chk("t1_pend_consumed",   {24'd0, pend_a},  32'd0);
    idle(GAP);
    chk("t1_busy_in_gap", {31'd0, busy_a}, 32'd1);
    idle(1);
    chk("t1_busy_done",   {31'd0, busy_a}, 32'd0);

    // Burst of three.
    pc_a = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(30);
    chk("t2_pulse_count", pc_a, 32'd3);
    chk("t2_busy_done",   {31'd0, busy_a}, 32'd0);

    // Saturation on the 2-bit counter: six events, four pulses, two lost.
    pc_a = 0;
    pc_b = 0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    chk("t3_b_overflow", {31'd0, ovf_b}, 32'd1);
    chk("t3_a_overflow", {31'd0, ovf_a}, 32'd0);
    idle(50);
    chk("t3_b_pulses", pc_b, 32'd4);
    chk("t3_a_pulses", pc_a, 32'd6);

    // Clear alone, then clear coincident with a loss, then accept at full
    // count coinciding with an emit.
    step(1'b0, 1'b1);
    chk("t4_clear", {31'd0, ovf_b}, 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("t4_set_wins", {31'd0, ovf_b}, 32'd1);
    step(1'b0, 1'b1);
    chk("t4_clear2", {31'd0, ovf_b}, 32'd0);
    idle(3);
    step(1'b1, 1'b0);
    chk("t4_full_emit_pulse", {31'd0, pulse_b}, 32'd1);
    chk("t4_full_emit_pend",  {30'd0, pend_b},  32'd3);
    chk("t4_full_emit_noovf", {31'd0, ovf_b},   32'd0);
    idle(60);

    // Randomized traffic at several event densities.
    for (int i = 0; i < 150; i++) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
    for (int i = 0; i < 150; i++) step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3);
    for (int i = 0; i < 100; i++) step($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 5);

    // Reset mid-GAP with two events pending: nothing emitted afterwards.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("t5_pend_before_rst", {24'd0, pend_a}, 32'd2);
    do_reset();
    pc_a = 0;
    pc_b = 0;
    idle(30);
    chk("t5_no_pulse_a", pc_a, 32'd0);
    chk("t5_no_pulse_b", pc_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
